// File: rtl/db9md_pad_responder_if.sv
// Pad-side bundle of the DB9 Mega Drive link: host SELECT and core buttons in,
// active-low pin levels and debug phase out.
interface db9md_pad_responder_if;
    logic        select_in;
    logic [11:0] buttons;
    logic [5:0]  pad_out;
    logic [2:0]  phase;

    // Host side: drives SELECT and the button state, observes the pins.
    modport master (
        output select_in,
        output buttons,
        input  pad_out,
        input  phase
    );

    // Responder side: the pad emulation itself.
    modport slave (
        input  select_in,
        input  buttons,
        output pad_out,
        output phase
    );
endinterface

// File: rtl/db9md_pad_responder.sv
// Mega Drive 3/6-button pad responder for the DB9 side of the USER port.
// The host toggles SELECT; the pad answers with six active-low pin levels
// {pin9,pin6,pin4,pin3,pin2,pin1} built from the core's 12-bit button vector.
// Define DB9MD_SIX_BUTTON_EN for the 6-button protocol (SELECT pulse counter
// plus idle timeout); without it the block is a plain 3-button pad.
module db9md_pad_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 60000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    db9md_pad_responder_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sel_s;
    logic [1:0]             cnt_q;
    logic [1:0]             cnt_d;
    logic [11:0]            btn_n;
    logic [5:0]             pad_d;
    logic [5:0]             pad_q;

    // Bring the asynchronous SELECT line into the clk domain (idle level is high).
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.select_in};
        end
    end

    assign sel_s = sync_q[SYNC_STAGES-1];

`ifdef DB9MD_SIX_BUTTON_EN
    localparam int unsigned      TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic               sel_dly_q;
    logic               sel_edge;
    logic               sel_rise;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;

    assign sel_edge = sel_s ^ sel_dly_q;
    assign sel_rise = sel_s & ~sel_dly_q;

    // Step the pulse counter on each rising SELECT; a quiet line returns it to the first step.
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (sel_edge) begin
            timer_d = '0;
            if (sel_rise) begin
                cnt_d = cnt_q + 2'd1;
            end
        end else begin
            if (timer_q != TIMER_MAX) begin
                timer_d = timer_q + TIMER_W'(1);
            end
            if (timer_q == TIMER_LAST) begin
                cnt_d = 2'd0;
            end
        end
    end

    // Edge-detect copy of SELECT, pulse counter and idle timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_dly_q <= 1'b1;
            cnt_q     <= 2'd0;
            timer_q   <= '0;
        end else begin
            sel_dly_q <= sel_s;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
        end
    end
`else
    // 3-button pad: always on the first step, no timer.
    logic unused_ok;

    assign cnt_q     = 2'd0;
    assign cnt_d     = 2'd0;
    assign unused_ok = &{1'b0, 32'(TIMEOUT_CYCLES)};
`endif

    assign btn_n = ~bus.buttons;

    // Pin mapping from SELECT and the step count. The step used is the one taking
    // effect this edge, so the row switches together with SELECT (no stale-row cycle).
    always_comb begin
        pad_d = 6'h3F;
        if (sel_s) begin
            if (cnt_d == 2'd3) begin
                // Extra buttons: pin1 Z, pin2 Y, pin3 X, pin4 Mode.
                pad_d = {btn_n[5], btn_n[4], btn_n[8], btn_n[9], btn_n[10], btn_n[11]};
            end else begin
                // Normal high row: pin1 U, pin2 D, pin3 L, pin4 R, pin6 B, pin9 C.
                pad_d = {btn_n[5], btn_n[4], btn_n[0], btn_n[1], btn_n[2], btn_n[3]};
            end
        end else begin
            case (cnt_d)
                2'd2:    pad_d = {btn_n[7], btn_n[6], 4'b0000};                // 6-button ID
                2'd3:    pad_d = {btn_n[7], btn_n[6], 4'b1111};
                default: pad_d = {btn_n[7], btn_n[6], 2'b00, btn_n[2], btn_n[3]};
            endcase
        end
    end

    // Register the pins so the host always samples clean levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_q <= 6'h3F;
        end else begin
            pad_q <= pad_d;
        end
    end

    assign bus.pad_out = pad_q;
    assign bus.phase   = {cnt_q, ~sel_s};

endmodule

// File: tb/tb_db9md_pad_responder.sv
// Directed bench for db9md_pad_responder. Covers both builds: the 6-button
// sequences are selected with DB9MD_SIX_BUTTON_EN, matching the RTL build.
module tb_db9md_pad_responder;

    localparam int unsigned TO   = 200;
    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    db9md_pad_responder_if bus ();

    db9md_pad_responder #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.select_in = 1'b1;
        clocks(2);
        reset = 1'b0;
        clocks(2);
    endtask

    task automatic pulse_low(input int n);
        bus.select_in = 1'b0;
        clocks(n);
        bus.select_in = 1'b1;
        clocks(n);
    endtask

    // Hold SELECT at v for 10 clocks, checking pins and phase midway.
    task automatic half(input logic v, input string tag, input logic [5:0] exp_pad,
                        input logic [2:0] exp_phase);
        bus.select_in = v;
        clocks(5);
        check({tag, " pad"}, 8'(bus.pad_out), 8'(exp_pad));
        check({tag, " phase"}, 8'(bus.phase), 8'(exp_phase));
        clocks(5);
    endtask

    logic [5:0] exp_lo[5];
    logic [5:0] exp_hi[5];
    logic [2:0] ph_lo[5];
    logic [2:0] ph_hi[5];
    logic [5:0] exp_t6_high;

    initial begin
`ifdef DB9MD_SIX_BUTTON_EN
        exp_lo      = '{6'h33, 6'h33, 6'h30, 6'h3F, 6'h33};
        exp_hi      = '{6'h3F, 6'h3F, 6'h33, 6'h3F, 6'h3F};
        ph_lo       = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b001};
        ph_hi       = '{3'b010, 3'b100, 3'b110, 3'b000, 3'b010};
        exp_t6_high = 6'h33;
`else
        exp_lo      = '{6'h33, 6'h33, 6'h33, 6'h33, 6'h33};
        exp_hi      = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
        ph_lo       = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        ph_hi       = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        exp_t6_high = 6'h3F;
`endif

        // Reset state, then U+B on the idle-high row one clock after release.
        reset         = 1'b1;
        bus.select_in = 1'b1;
        bus.buttons   = 12'h018;
        clocks(3);
        check("reset pad", 8'(bus.pad_out), 8'h3F);
        check("reset phase", 8'(bus.phase), 8'h00);
        reset = 1'b0;
        clocks(1);
        check("t1 pad", 8'(bus.pad_out), 8'h2E);
        check("t1 phase", 8'(bus.phase), 8'h00);

        // Button change is registered: unchanged before the edge, visible one clock later.
        bus.buttons = 12'h000;
        #1;
        check("btn before edge", 8'(bus.pad_out), 8'h2E);
        clocks(1);
        check("btn after 1clk", 8'(bus.pad_out), 8'h3F);

        // SELECT falls with A+Start held: exactly SYNC+1 clocks to the low row.
        bus.buttons   = 12'h0C0;
        bus.select_in = 1'b0;
        clocks(SYNC);
        check("t2 before latency", 8'(bus.pad_out), 8'h3F);
        clocks(1);
        check("t2 at latency", 8'(bus.pad_out), 8'h03);
        check("t2 phase", 8'(bus.phase), 8'h01);
        clocks(7);
        bus.select_in = 1'b1;
        clocks(10);

        // Five low pulses with X+Mode held, walking the full step cycle and the wrap.
        apply_reset();
        bus.buttons = 12'h300;
        for (int i = 0; i < 5; i++) begin
            half(1'b0, $sformatf("t3 low%0d", i + 1), exp_lo[i], ph_lo[i]);
            half(1'b1, $sformatf("t3 high%0d", i + 2), exp_hi[i], ph_hi[i]);
        end

`ifdef DB9MD_SIX_BUTTON_EN
        // Idle timeout: two pulses, a long quiet high, then the next low is a first-step row.
        apply_reset();
        bus.buttons = 12'h000;
        pulse_low(10);
        pulse_low(10);
        clocks(20);
        check("t4 before timeout phase", 8'(bus.phase), 8'h04);
        clocks(TO + 5);
        check("t4 after timeout phase", 8'(bus.phase), 8'h00);
        half(1'b0, "t4 low", 6'h33, 3'b001);
`endif

        // Reset during the 4th high clears the outputs at once; next low is a normal row.
        apply_reset();
        bus.buttons = 12'h300;
        pulse_low(10);
        pulse_low(10);
        bus.select_in = 1'b0;
        clocks(10);
        bus.select_in = 1'b1;
        clocks(5);
        check("t6 4th high pad", 8'(bus.pad_out), 8'(exp_t6_high));
        reset = 1'b1;
        #1;
        check("t6 reset pad", 8'(bus.pad_out), 8'h3F);
        check("t6 reset phase", 8'(bus.phase), 8'h00);
        clocks(2);
        reset = 1'b0;
        clocks(3);
        half(1'b0, "t6 low after reset", 6'h33, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
